// File: rtl/bus_pkg.sv
// Shared types and default constants for the bus decoder and its wait/timeout timer.
package bus_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_WAIT_WIDTH = 4;
  localparam int DEF_TIMEOUT    = 64;

  typedef logic [DEF_ADDR_WIDTH-1:0] bus_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] bus_data_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERR    = 2'd3
  } bus_state_e;

endpackage

// File: rtl/bus_wait_timer.sv
// Loadable wait down-counter plus peripheral-wait timeout counter, both driven by the decoder FSM.
// The timeout counter exists only when BUS_DECODER_TIMEOUT_EN is defined.
module bus_wait_timer
  import bus_pkg::*;
#(
  parameter int WAIT_WIDTH = DEF_WAIT_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wait_load,
  input  logic [WAIT_WIDTH-1:0] wait_val,
  input  logic                  wait_dec,
  output logic                  wait_zero,
  input  logic                  to_inc,
  input  logic                  to_clr,
  output logic                  to_hit
);

  logic [WAIT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (wait_load) begin
      wait_cnt_d = wait_val;
    end else if (wait_dec && (wait_cnt_q != '0)) begin
      wait_cnt_d = wait_cnt_q - WAIT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign wait_zero = (wait_cnt_q == '0);

`ifdef BUS_DECODER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (to_clr) begin
      to_cnt_d = '0;
    end else if (to_inc) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  // High on the TIMEOUT-th consecutive stalled cycle, so the FSM leaves on that edge.
  assign to_hit = (to_cnt_q == TO_LAST);
`else
  logic unused_to;
  assign unused_to = to_inc ^ to_clr;
  assign to_hit    = 1'b0;
`endif

endmodule

// File: rtl/bus_decoder.sv
// CPU memory-region decoder with per-region wait insertion; optional peripheral-wait
// timeout (ERR state, bus_err pulse) is enabled by defining BUS_DECODER_TIMEOUT_EN.
module bus_decoder
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int REGION_BITS = 1,
  parameter int WAIT_WIDTH  = DEF_WAIT_WIDTH,
  parameter logic [(2**REGION_BITS)-1:0][WAIT_WIDTH-1:0] WAIT_CYCLES = '0,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mreq_n,
  input  logic                         iorq_n,
  input  logic                         rd_n,
  input  logic                         wr_n,
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic                         periph_wait_n,
  output logic [(2**REGION_BITS)-1:0]  en_n,
  output logic                         buswait_n,
  output logic                         bus_err,
  output logic [REGION_BITS-1:0]       err_region
);

  bus_state_e             state_q, state_d;
  logic [REGION_BITS-1:0] region;
  logic [WAIT_WIDTH-1:0]  region_wait;
  logic                   mem_cycle, start, strobe_off;
  logic                   wait_load, wait_dec, wait_zero;
  logic                   to_inc, to_clr, to_hit;
  logic [WAIT_WIDTH-1:0]  wait_val;
  logic                   unused_addr;

  assign region      = addr[ADDR_WIDTH-1 -: REGION_BITS];
  assign unused_addr = ^addr[ADDR_WIDTH-REGION_BITS-1:0];
  assign region_wait = WAIT_CYCLES[region];
  // An I/O request never counts as a memory cycle, even if mreq_n glitches low with it.
  assign mem_cycle   = !mreq_n && iorq_n;
  assign start       = (state_q == ST_IDLE) && mem_cycle && (!rd_n || !wr_n);
  assign strobe_off  = mreq_n || (rd_n && wr_n);

  always_comb begin
    en_n = '1;
    if (mem_cycle) begin
      en_n[region] = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (region_wait == '0) begin
            state_d = ST_ACTIVE;
          end else begin
            state_d   = ST_WAIT;
            wait_load = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (strobe_off)     state_d = ST_IDLE;
        else if (wait_zero) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (strobe_off)                    state_d = ST_IDLE;
        else if (!periph_wait_n && to_hit) state_d = ST_ERR;
      end
      ST_ERR: begin
        if (strobe_off) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wait_val = region_wait - WAIT_WIDTH'(1);
  assign wait_dec = (state_q == ST_WAIT);
  assign to_clr   = (state_q != ST_ACTIVE) || periph_wait_n;
  assign to_inc   = !to_clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    buswait_n = periph_wait_n;
    if (reset) begin
      buswait_n = 1'b1;
    end else begin
      case (state_q)
        ST_WAIT: buswait_n = 1'b0;
        ST_ERR:  buswait_n = 1'b1;
        default: buswait_n = periph_wait_n;
      endcase
    end
  end

  bus_wait_timer #(
    .WAIT_WIDTH (WAIT_WIDTH),
    .TIMEOUT    (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .wait_load (wait_load),
    .wait_val  (wait_val),
    .wait_dec  (wait_dec),
    .wait_zero (wait_zero),
    .to_inc    (to_inc),
    .to_clr    (to_clr),
    .to_hit    (to_hit)
  );

`ifdef BUS_DECODER_TIMEOUT_EN
  logic [REGION_BITS-1:0] region_q, region_d;
  logic [REGION_BITS-1:0] err_region_q, err_region_d;
  logic                   bus_err_q, bus_err_d;

  always_comb begin
    region_d     = start ? region : region_q;
    bus_err_d    = (state_q == ST_ACTIVE) && (state_d == ST_ERR);
    err_region_d = bus_err_d ? region_q : err_region_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      region_q     <= '0;
      bus_err_q    <= 1'b0;
      err_region_q <= '0;
    end else begin
      region_q     <= region_d;
      bus_err_q    <= bus_err_d;
      err_region_q <= err_region_d;
    end
  end

  assign bus_err    = bus_err_q;
  assign err_region = err_region_q;
`else
  assign bus_err    = 1'b0;
  assign err_region = '0;
`endif

endmodule

// File: tb/tb_bus_decoder.sv
// Directed, table-driven bench for bus_decoder (REGION_BITS=1, waits {3,0}, TIMEOUT=8).
module tb_bus_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mreq_n, iorq_n, rd_n, wr_n, periph_wait_n;
  logic [15:0] addr;
  logic [1:0]  en_n;
  logic        buswait_n, bus_err;
  logic [0:0]  err_region;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic        rst, mreq_n, iorq_n, rd_n, wr_n, periph;
    logic [15:0] addr;
    logic [1:0]  exp_en;
    logic        exp_bw, exp_err, exp_reg;
  } vec_t;

  vec_t vecs[$];

  bus_decoder #(
    .ADDR_WIDTH  (16),
    .REGION_BITS (1),
    .WAIT_WIDTH  (4),
    .WAIT_CYCLES ({4'd3, 4'd0}),
    .TIMEOUT     (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mreq_n        (mreq_n),
    .iorq_n        (iorq_n),
    .rd_n          (rd_n),
    .wr_n          (wr_n),
    .addr          (addr),
    .periph_wait_n (periph_wait_n),
    .en_n          (en_n),
    .buswait_n     (buswait_n),
    .bus_err       (bus_err),
    .err_region    (err_region)
  );

  always #5 clk = ~clk;

  task automatic add(string name, logic rst, logic mq, logic io, logic rd, logic wr,
                     logic pw, logic [15:0] a, logic [1:0] een, logic ebw, logic eerr,
                     logic ereg);
    vec_t v;
    v.name = name; v.rst = rst; v.mreq_n = mq; v.iorq_n = io; v.rd_n = rd; v.wr_n = wr;
    v.periph = pw; v.addr = a; v.exp_en = een; v.exp_bw = ebw; v.exp_err = eerr;
    v.exp_reg = ereg;
    vecs.push_back(v);
  endtask

  task automatic check(string name, logic [1:0] een, logic ebw, logic eerr, logic ereg);
    tests++;
    if (en_n !== een || buswait_n !== ebw || bus_err !== eerr || err_region[0] !== ereg) begin
      fails++;
      $display("FAIL %s: got en_n=%b buswait_n=%b bus_err=%b err_region=%b, want %b %b %b %b",
               name, en_n, buswait_n, bus_err, err_region, een, ebw, eerr, ereg);
    end
  endtask

  // Drive one cycle of inputs, clock it in, then check just after the edge.
  task automatic cycle(logic rst, logic mq, logic io, logic rd, logic wr, logic pw,
                       logic [15:0] a);
    reset = rst; mreq_n = mq; iorq_n = io; rd_n = rd; wr_n = wr; periph_wait_n = pw; addr = a;
    @(posedge clk);
    #1;
  endtask

  logic macro_on;
  logic exp_bw, exp_err;

  initial begin
`ifdef BUS_DECODER_TIMEOUT_EN
    macro_on = 1'b1;
`else
    macro_on = 1'b0;
`endif
    reset = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    periph_wait_n = 1'b1; addr = '0;

    //   name          rst mq io rd wr pw addr      en     bw err reg
    add("rst_c1",      1, 1, 1, 1, 1, 0, 16'h0000, 2'b11, 1, 0, 0);
    add("rst_c2",      1, 1, 1, 1, 1, 1, 16'h0000, 2'b11, 1, 0, 0);
    add("idle",        0, 1, 1, 1, 1, 1, 16'h0000, 2'b11, 1, 0, 0);
    add("r1_wait1",    0, 0, 1, 0, 1, 1, 16'h8000, 2'b01, 0, 0, 0);
    add("r1_wait2",    0, 0, 1, 0, 1, 1, 16'h8000, 2'b01, 0, 0, 0);
    add("r1_wait3",    0, 0, 1, 0, 1, 1, 16'h8000, 2'b01, 0, 0, 0);
    add("r1_active",   0, 0, 1, 0, 1, 1, 16'h8000, 2'b01, 1, 0, 0);
    add("r1_pwait",    0, 0, 1, 0, 1, 0, 16'h8000, 2'b01, 0, 0, 0);
    add("r1_pready",   0, 0, 1, 0, 1, 1, 16'h8000, 2'b01, 1, 0, 0);
    add("r1_release",  0, 1, 1, 1, 1, 1, 16'h8000, 2'b11, 1, 0, 0);
    add("r0_start",    0, 0, 1, 0, 1, 1, 16'h0010, 2'b10, 1, 0, 0);
    add("r0_active",   0, 0, 1, 0, 1, 1, 16'h0010, 2'b10, 1, 0, 0);
    add("r0_release",  0, 1, 1, 1, 1, 1, 16'h0010, 2'b11, 1, 0, 0);
    add("io_c1",       0, 1, 0, 0, 1, 1, 16'h8000, 2'b11, 1, 0, 0);
    add("io_c2",       0, 1, 0, 0, 1, 1, 16'h8000, 2'b11, 1, 0, 0);
    add("io_release",  0, 1, 1, 1, 1, 1, 16'h8000, 2'b11, 1, 0, 0);
    add("wr_wait1",    0, 0, 1, 1, 0, 1, 16'h8000, 2'b01, 0, 0, 0);
    add("wr_abort",    0, 0, 1, 1, 1, 1, 16'h8000, 2'b01, 1, 0, 0);
    add("wr_idle",     0, 1, 1, 1, 1, 1, 16'h8000, 2'b11, 1, 0, 0);
    add("latch_start", 0, 0, 1, 0, 1, 1, 16'h0010, 2'b10, 1, 0, 0);
    add("latch_move",  0, 0, 1, 0, 1, 1, 16'h8000, 2'b01, 1, 0, 0);
    add("latch_rel",   0, 1, 1, 1, 1, 1, 16'h8000, 2'b11, 1, 0, 0);
    add("rstw_wait1",  0, 0, 1, 0, 1, 1, 16'h8000, 2'b01, 0, 0, 0);
    add("rstw_wait2",  0, 0, 1, 0, 1, 1, 16'h8000, 2'b01, 0, 0, 0);
    add("rstw_reset",  1, 0, 1, 0, 1, 1, 16'h8000, 2'b01, 1, 0, 0);
    add("rstw_idle",   0, 1, 1, 1, 1, 1, 16'h8000, 2'b11, 1, 0, 0);

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].mreq_n, vecs[i].iorq_n, vecs[i].rd_n, vecs[i].wr_n,
            vecs[i].periph, vecs[i].addr);
      check(vecs[i].name, vecs[i].exp_en, vecs[i].exp_bw, vecs[i].exp_err, vecs[i].exp_reg);
    end

    // Peripheral stuck low in region 1: 3 wait cycles, then ACTIVE from cycle 4; the
    // 8th stalled ACTIVE cycle ends at edge 12, so ERR (and the bus_err pulse) follows it.
    for (int c = 1; c <= 16; c++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h8000);
      exp_bw  = macro_on && (c >= 12);
      exp_err = macro_on && (c == 12);
      check($sformatf("tmo_c%0d", c), 2'b01, exp_bw, exp_err, macro_on && (c >= 12));
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h8000);
    check("tmo_release", 2'b11, 1'b1, 1'b0, macro_on);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h8000);
    check("tmo_idle_follow", 2'b11, 1'b0, 1'b0, macro_on);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000);
    check("tmo_reset_clr", 2'b11, 1'b1, 1'b0, 1'b0);

    // Reset while in ACTIVE with the peripheral stalled: IDLE next edge, no error pulse.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0010);
    check("rsta_active", 2'b10, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0010);
    check("rsta_reset", 2'b10, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0010);
    check("rsta_idle", 2'b11, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
